// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// Shares one single-port memory between instruction fetch (read-only) and
// the MEM stage (load/store). One transaction is in flight at a time. The
// data port has fixed priority, but after MAX_DATA_STREAK consecutive data
// wins while fetch is waiting, fetch is served. A watchdog turns a memory
// that never answers into an error completion.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   if_req/if_addr               fetch request (held until if_gnt)
//   if_gnt                       combinational accept pulse
//   if_rvalid/if_rdata/if_err    registered fetch completion
//   d_req/d_we/d_be/d_addr/d_wdata  data request (held until d_gnt)
//   d_gnt                        combinational accept pulse
//   d_rvalid/d_rdata/d_err       registered data completion (stores too)
//   mem_req/we/be/addr/wdata     registered memory request, held until mem_gnt
//   mem_gnt/mem_rvalid/mem_rdata memory handshake and in-order response
//   busy                         high whenever the FSM is not IDLE
module riscv_mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int STK_W = $clog2(MAX_DATA_STREAK + 1);
  // Counter value on the last cycle before the watchdog fires.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               owner_d_q, owner_d_d;   // 1: data port owns the transaction
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic [STK_W-1:0]   streak_q, streak_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [BE_W-1:0]    mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic               if_err_q, if_err_d;
  logic               d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
  logic               d_err_q, d_err_d;

  logic               if_gnt_s, d_gnt_s, fetch_win_s;
  logic               cmp_s, cmp_err_s;
  logic [DATA_W-1:0]  cmp_data_s;

  // Next-state, arbitration, watchdog and completion logic.
  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    tmo_d       = tmo_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_err_d    = 1'b0;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = 1'b0;
    if_gnt_s    = 1'b0;
    d_gnt_s     = 1'b0;
    fetch_win_s = 1'b0;
    cmp_s       = 1'b0;
    cmp_err_s   = 1'b0;
    cmp_data_s  = {DATA_W{1'b0}};

    case (state_q)
      S_IDLE: begin
        if (d_req || if_req) begin
          // Fetch only beats a waiting data request once the streak is spent.
          fetch_win_s = !d_req || (if_req && (streak_q == STK_MAX));
          mem_req_d   = 1'b1;
          tmo_d       = {CNT_W{1'b0}};
          state_d     = S_REQ;
          if (fetch_win_s) begin
            if_gnt_s    = 1'b1;
            owner_d_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_be_d    = {BE_W{1'b1}};
            mem_addr_d  = if_addr;
            mem_wdata_d = {DATA_W{1'b0}};
            streak_d    = {STK_W{1'b0}};
          end else begin
            d_gnt_s     = 1'b1;
            owner_d_d   = 1'b1;
            mem_we_d    = d_we;
            mem_be_d    = d_be;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // The streak only grows while fetch is actually being held off.
            if (if_req) begin
              streak_d = (streak_q == STK_MAX) ? streak_q : streak_q + STK_W'(1);
            end else begin
              streak_d = {STK_W{1'b0}};
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        tmo_d = tmo_q + CNT_W'(1);
        if (tmo_q == TMO_LAST) begin
          cmp_s     = 1'b1;
          cmp_err_s = 1'b1;
        end else if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = S_RESP;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RESP: begin
        tmo_d = tmo_q + CNT_W'(1);
        // A response arriving on the watchdog's last cycle still counts.
        if (mem_rvalid) begin
          cmp_s      = 1'b1;
          cmp_data_s = mem_we_q ? {DATA_W{1'b0}} : mem_rdata;
        end else if (tmo_q == TMO_LAST) begin
          cmp_s     = 1'b1;
          cmp_err_s = 1'b1;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completion is routed to the owner only; the other port holds its data.
    if (cmp_s) begin
      mem_req_d = 1'b0;
      state_d   = S_IDLE;
      if (owner_d_q) begin
        d_rvalid_d = 1'b1;
        d_err_d    = cmp_err_s;
        d_rdata_d  = cmp_data_s;
      end else begin
        if_rvalid_d = 1'b1;
        if_err_d    = cmp_err_s;
        if_rdata_d  = cmp_data_s;
      end
    end else begin
      owner_d_d = owner_d_d;
    end
  end

  // State, payload and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_d_q   <= 1'b0;
      tmo_q       <= {CNT_W{1'b0}};
      streak_q    <= {STK_W{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= {BE_W{1'b0}};
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= {DATA_W{1'b0}};
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= {DATA_W{1'b0}};
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_d_q   <= owner_d_d;
      tmo_q       <= tmo_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  // Grants are combinational; gating with reset_n keeps them low during reset.
  assign if_gnt    = if_gnt_s & reset_n;
  assign d_gnt     = d_gnt_s & reset_n;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
module tb_riscv_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // memory device model
  int          gnt_lat, rsp_lat, m_wait, pend_cnt;
  bit          hang, force_rv, rand_lat;
  logic [31:0] pend_data;
  logic [31:0] mem_arr [16];
  // requester-level reference
  logic [31:0] ref_arr [16];
  int          g, k, n, sref;
  bit          exp_f, exp_is_d, outstanding, f_wait, d_wait, f_got, d_got;
  logic [31:0] exp_data, v;

  riscv_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(64), .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then let the memory device react to the registered request.
  task automatic cycle();
    @(posedge clk);
    #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (force_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_BAD0;
      force_rv   = 1'b0;
    end else if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_data;
      end
    end
    if (mem_req) begin
      if (m_wait >= gnt_lat) begin
        mem_gnt = 1'b1;
        m_wait  = 0;
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem_arr[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          pend_data = 32'hFFFF_FFFF;
        end else begin
          pend_data = mem_arr[mem_addr[5:2]];
        end
        pend_cnt = hang ? 0 : rsp_lat;
        if (rand_lat) begin
          gnt_lat = $urandom_range(0, 3);
          rsp_lat = $urandom_range(1, 3);
        end
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic wait_rv(input bit want_d, input int budget, output int cnt);
    cnt = 0;
    do begin
      cycle();
      #1;
      cnt++;
    end while (!(want_d ? d_rvalid : if_rvalid) && cnt < budget);
  endtask

  initial begin
    reset_n = 1'b0; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_be = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    gnt_lat = 0; rsp_lat = 1; m_wait = 0; pend_cnt = 0;
    hang = 1'b0; force_rv = 1'b0; rand_lat = 1'b0; pend_data = 32'd0;
    for (int i = 0; i < 16; i++) mem_arr[i] = 32'(i) * 32'h0101_0101;

    // reset: all outputs low even with both requesters asserting
    if_req = 1'b1; d_req = 1'b1;
    #12;
    chk("rst_outputs", 64'(|{if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata,
        d_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy}), 64'd0);
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;

    // single fetch, best-case latency
    mem_arr[0] = 32'hDEAD_BEEF;
    cycle(); if_req = 1'b1; if_addr = 32'h100; #1;
    chk("lat_if_gnt", 64'(if_gnt), 64'd1);
    chk("lat_d_gnt", 64'(d_gnt), 64'd0);
    cycle(); if_req = 1'b0; #1;
    chk("lat_mem_req", 64'(mem_req), 64'd1);
    chk("lat_mem_addr", 64'(mem_addr), 64'h100);
    chk("lat_mem_we", 64'(mem_we), 64'd0);
    chk("lat_mem_be", 64'(mem_be), 64'hF);
    cycle(); #1;
    chk("lat_rv_early", 64'(if_rvalid), 64'd0);
    chk("lat_busy", 64'(busy), 64'd1);
    cycle(); #1;
    chk("lat_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("lat_if_rdata", 64'(if_rdata), 64'hDEAD_BEEF);
    chk("lat_if_err", 64'(if_err), 64'd0);
    chk("lat_d_rvalid", 64'(d_rvalid), 64'd0);

    // both requesters held: D,D,D,D,F repeating
    g = 0; k = 0;
    while (g < 12 && k < 100) begin
      cycle(); d_req = 1'b1; if_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; if_addr = 32'h4; #1;
      k++;
      if (if_gnt || d_gnt) begin
        chk("streak_order", 64'({if_gnt, d_gnt}), 64'(((g % 5) == 4) ? 2'b10 : 2'b01));
        g++;
      end
    end
    chk("streak_count", 64'(g), 64'd12);
    cycle(); d_req = 1'b0; if_req = 1'b0;
    repeat (6) cycle();

    // store with partial byte enables
    cycle(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h40; d_wdata = 32'h1234; #1;
    chk("st_gnt", 64'(d_gnt), 64'd1);
    cycle(); d_req = 1'b0; d_we = 1'b0; #1;
    chk("st_mem_we", 64'(mem_we), 64'd1);
    chk("st_mem_be", 64'(mem_be), 64'h3);
    chk("st_mem_wdata", 64'(mem_wdata), 64'h1234);
    chk("st_mem_addr", 64'(mem_addr), 64'h40);
    wait_rv(1'b1, 10, k);
    chk("st_rvalid", 64'(d_rvalid), 64'd1);
    chk("st_rdata", 64'(d_rdata), 64'd0);
    chk("st_err", 64'(d_err), 64'd0);
    // read back: only the low two bytes were replaced
    cycle(); d_req = 1'b1; d_addr = 32'h40; #1;
    chk("ld_gnt", 64'(d_gnt), 64'd1);
    cycle(); d_req = 1'b0;
    wait_rv(1'b1, 10, k);
    chk("ld_rvalid", 64'(d_rvalid), 64'd1);
    chk("ld_rdata", 64'(d_rdata), 64'hDEAD_1234);

    // memory grant delayed five cycles
    gnt_lat = 5;
    cycle(); if_req = 1'b1; if_addr = 32'h24; #1;
    chk("dly_gnt", 64'(if_gnt), 64'd1);
    for (int i = 0; i < 5; i++) begin
      cycle(); if_req = 1'b0; #1;
      chk("dly_mem_req", 64'(mem_req), 64'd1);
      chk("dly_mem_addr", 64'(mem_addr), 64'h24);
    end
    n = 0;
    repeat (15) begin
      cycle(); #1;
      if (if_rvalid || d_rvalid) n++;
    end
    chk("dly_one_cpl", 64'(n), 64'd1);
    gnt_lat = 0;

    // memory never answers: error completion 64 cycles after REQ
    hang = 1'b1;
    cycle(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; #1;
    chk("tmo_gnt", 64'(d_gnt), 64'd1);
    cycle(); d_req = 1'b0; #1;
    k = 1;
    while (!d_rvalid && k < 100) begin
      cycle(); #1;
      k++;
    end
    chk("tmo_rvalid", 64'(d_rvalid), 64'd1);
    chk("tmo_cycles", 64'(k), 64'd65);
    chk("tmo_err", 64'(d_err), 64'd1);
    chk("tmo_rdata", 64'(d_rdata), 64'd0);
    hang = 1'b0;
    force_rv = 1'b1;
    n = 0;
    repeat (4) begin
      cycle(); #1;
      if (if_rvalid || d_rvalid) n++;
    end
    chk("late_ignored", 64'(n), 64'd0);
    chk("late_rdata_held", 64'(d_rdata), 64'd0);
    chk("late_err_low", 64'(d_err), 64'd0);
    chk("late_busy", 64'(busy), 64'd0);

    // reset while waiting for the response
    rsp_lat = 4;
    cycle(); d_req = 1'b1; d_addr = 32'hC; #1;
    chk("mrst_gnt", 64'(d_gnt), 64'd1);
    cycle(); d_req = 1'b0; #1;
    cycle(); #1;
    chk("mrst_busy", 64'(busy), 64'd1);
    if_req = 1'b1; reset_n = 1'b0; #1;
    chk("mrst_outputs", 64'(|{if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata,
        d_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy}), 64'd0);
    if_req = 1'b0; pend_cnt = 0; m_wait = 0; rsp_lat = 1;
    @(posedge clk); #1; reset_n = 1'b1;
    n = 0;
    repeat (4) begin
      cycle(); #1;
      if (if_rvalid || d_rvalid) n++;
    end
    chk("mrst_no_cpl", 64'(n), 64'd0);
    chk("mrst_idle", 64'(busy), 64'd0);
    cycle(); d_req = 1'b1; d_addr = 32'hC; #1;
    chk("mrst_next_gnt", 64'(d_gnt), 64'd1);
    cycle(); d_req = 1'b0;
    wait_rv(1'b1, 10, k);
    chk("mrst_next_rvalid", 64'(d_rvalid), 64'd1);
    chk("mrst_next_rdata", 64'(d_rdata), 64'h0303_0303);

    // randomized traffic against the requester-level reference
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      mem_arr[i] = v;
      ref_arr[i] = v;
    end
    rand_lat = 1'b1; sref = 0; outstanding = 1'b0;
    f_wait = 1'b0; d_wait = 1'b0; f_got = 1'b0; d_got = 1'b0;
    exp_is_d = 1'b0; exp_data = 32'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      cycle();
      if (if_rvalid || d_rvalid) begin
        chk("rnd_cpl_pending", 64'(outstanding), 64'd1);
        chk("rnd_cpl_port", 64'({if_rvalid, d_rvalid}), 64'(exp_is_d ? 2'b01 : 2'b10));
        chk("rnd_cpl_data", 64'(exp_is_d ? d_rdata : if_rdata), 64'(exp_data));
        chk("rnd_cpl_err", 64'(if_err | d_err), 64'd0);
        outstanding = 1'b0;
        if (if_rvalid) f_wait = 1'b0;
        if (d_rvalid) d_wait = 1'b0;
      end
      if (f_got) begin if_req = 1'b0; f_got = 1'b0; f_wait = 1'b1; end
      if (d_got) begin d_req = 1'b0; d_got = 1'b0; d_wait = 1'b1; end
      if (!if_req && !f_wait && cyc < 560 && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && !d_wait && cyc < 560 && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
        d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
      end
      #1;
      if (!outstanding && (if_req || d_req)) begin
        exp_f = !d_req || (if_req && sref == MAXS);
        chk("rnd_gnt", 64'({if_gnt, d_gnt}), 64'(exp_f ? 2'b10 : 2'b01));
        if (exp_f) begin
          sref = 0; exp_is_d = 1'b0; exp_data = ref_arr[if_addr[5:2]]; f_got = 1'b1;
        end else begin
          sref = if_req ? ((sref < MAXS) ? sref + 1 : sref) : 0;
          exp_is_d = 1'b1; d_got = 1'b1;
          if (d_we) begin
            for (int b = 0; b < 4; b++)
              if (d_be[b]) ref_arr[d_addr[5:2]][8*b +: 8] = d_wdata[8*b +: 8];
            exp_data = 32'd0;
          end else begin
            exp_data = ref_arr[d_addr[5:2]];
          end
        end
        outstanding = 1'b1;
      end else begin
        chk("rnd_no_gnt", 64'(if_gnt | d_gnt), 64'd0);
      end
    end
    chk("rnd_drained", 64'(outstanding | if_req | d_req | busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
